// File: rtl/i2c_slave_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : i2c_slave_responder_if                                |
// | Brief    : I2C pin levels, open-drain SDA control and register   |
// |            write strobe bundle for the I2C target responder.     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface i2c_slave_responder_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic       busy;
    logic       reg_wr_pulse;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;

    modport slave (
        input  scl_i, sda_i,
        output sda_oe, busy, reg_wr_pulse, reg_addr, reg_wdata
    );

    modport master (
        output scl_i, sda_i,
        input  sda_oe, busy, reg_wr_pulse, reg_addr, reg_wdata
    );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : i2c_slave_responder                                   |
// | Brief    : I2C target with a small byte register file; ACKs its  |
// |            address, takes a register pointer, accepts burst      |
// |            writes and serves burst reads via open-drain SDA.     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h68,
    parameter int         NO_OF_REG     = 4,
    parameter int         DATA_WIDTH    = 8
) (
    input  wire logic            pclk,
    input  wire logic            areset,
    i2c_slave_responder_if.slave bus
);
    localparam int         IDX_W     = (NO_OF_REG > 1) ? $clog2(NO_OF_REG) : 1;
    localparam logic [7:0] LAST_REG  = 8'(NO_OF_REG - 1);
    localparam logic [8:0] REG_LIMIT = 9'(NO_OF_REG);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG_ADDR, REG_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    logic [1:0]            rst_pipe;
    logic                  rst_n;
    logic                  scl_meta, scl_sync, scl_hist;
    logic                  sda_meta, sda_sync, sda_hist;
    logic                  scl_rise, scl_fall, start_det, stop_det;
    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] shift, shift_nx, byte_in, rd_byte, wdata, wdata_nx;
    logic [2:0]            bit_cnt, bit_cnt_nx;
    logic                  ack_phase, ack_phase_nx;
    logic [7:0]            ptr, ptr_nx, next_ptr;
    logic                  drive_low, drive_low_nx, active, active_nx;
    logic                  wr_pulse, wr_pulse_nx, wr_en;
    logic [DATA_WIDTH-1:0] regs [NO_OF_REG];

    // Reset asserts immediately and is released two pclk later.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) rst_pipe <= 2'b00;
        else         rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    // Two-flop synchronizers plus a history flop for edge detection.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            {scl_meta, scl_sync, scl_hist} <= 3'b111;
            {sda_meta, sda_sync, sda_hist} <= 3'b111;
        end else begin
            {scl_meta, scl_sync, scl_hist} <= {bus.scl_i, scl_meta, scl_sync};
            {sda_meta, sda_sync, sda_hist} <= {bus.sda_i, sda_meta, sda_sync};
        end
    end

    assign scl_rise  = scl_sync & ~scl_hist;
    assign scl_fall  = ~scl_sync & scl_hist;
    assign start_det = scl_sync & scl_hist & sda_hist & ~sda_sync;
    assign stop_det  = scl_sync & scl_hist & ~sda_hist & sda_sync;
    assign byte_in   = {shift[DATA_WIDTH-2:0], sda_sync};
    assign rd_byte   = regs[ptr[IDX_W-1:0]];
    assign next_ptr  = (ptr == LAST_REG) ? 8'd0 : ptr + 8'd1;

    // State and datapath registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= 3'd0;
            ack_phase <= 1'b0;
            ptr       <= 8'd0;
            drive_low <= 1'b0;
            active    <= 1'b0;
            wr_pulse  <= 1'b0;
            wdata     <= '0;
        end else begin
            state     <= state_nx;
            shift     <= shift_nx;
            bit_cnt   <= bit_cnt_nx;
            ack_phase <= ack_phase_nx;
            ptr       <= ptr_nx;
            drive_low <= drive_low_nx;
            active    <= active_nx;
            wr_pulse  <= wr_pulse_nx;
            wdata     <= wdata_nx;
        end
    end

    // Next-state logic; ACK states use ack_phase to tell the fall that
    // opens the ACK bit from the fall that closes it.
    always_comb begin
        state_nx     = state;
        shift_nx     = shift;
        bit_cnt_nx   = bit_cnt;
        ack_phase_nx = ack_phase;
        ptr_nx       = ptr;
        drive_low_nx = drive_low;
        active_nx    = active;
        wr_pulse_nx  = 1'b0;
        wdata_nx     = wdata;
        wr_en        = 1'b0;
        if (start_det) begin
            state_nx     = ADDR;
            bit_cnt_nx   = 3'd0;
            ack_phase_nx = 1'b0;
            drive_low_nx = 1'b0;
        end else if (stop_det) begin
            state_nx     = IDLE;
            ack_phase_nx = 1'b0;
            drive_low_nx = 1'b0;
            active_nx    = 1'b0;
        end else begin
            case (state)
                ADDR, REG_ADDR, WR_DATA: begin
                    if (scl_rise) begin
                        shift_nx   = byte_in;
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ack_phase_nx = 1'b0;
                            if (state == ADDR) begin
                                if (byte_in[DATA_WIDTH-1:1] == SLAVE_ADDRESS) begin
                                    state_nx  = ADDR_ACK;
                                    active_nx = 1'b1;
                                end else begin
                                    state_nx  = IGNORE;
                                    active_nx = 1'b0;
                                end
                            end else if (state == REG_ADDR) begin
                                if ({1'b0, byte_in} < REG_LIMIT) begin
                                    state_nx = REG_ACK;
                                    ptr_nx   = byte_in;
                                end else begin
                                    state_nx = IGNORE;
                                end
                            end else begin
                                state_nx    = WR_ACK;
                                wr_en       = 1'b1;
                                wr_pulse_nx = 1'b1;
                                wdata_nx    = byte_in;
                            end
                        end
                    end
                end
                ADDR_ACK, REG_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            drive_low_nx = 1'b1;
                            ack_phase_nx = 1'b1;
                        end else begin
                            ack_phase_nx = 1'b0;
                            bit_cnt_nx   = 3'd0;
                            drive_low_nx = 1'b0;
                            if (state == ADDR_ACK) begin
                                if (shift[0]) begin
                                    state_nx     = RD_DATA;
                                    shift_nx     = rd_byte;
                                    drive_low_nx = ~rd_byte[DATA_WIDTH-1];
                                end else begin
                                    state_nx = REG_ADDR;
                                end
                            end else if (state == REG_ACK) begin
                                state_nx = WR_DATA;
                            end else begin
                                state_nx = WR_DATA;
                                ptr_nx   = next_ptr;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_nx = bit_cnt + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            drive_low_nx = 1'b0;
                            ack_phase_nx = 1'b0;
                            state_nx     = RD_ACK;
                        end else begin
                            shift_nx     = {shift[DATA_WIDTH-2:0], 1'b0};
                            drive_low_nx = ~shift[DATA_WIDTH-2];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_sync) begin
                            ptr_nx       = next_ptr;
                            ack_phase_nx = 1'b1;
                        end else begin
                            state_nx = IGNORE;
                        end
                    end else if (scl_fall && ack_phase) begin
                        state_nx     = RD_DATA;
                        shift_nx     = rd_byte;
                        drive_low_nx = ~rd_byte[DATA_WIDTH-1];
                        bit_cnt_nx   = 3'd0;
                        ack_phase_nx = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file, written at the eighth sampled bit of a data byte.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NO_OF_REG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[ptr[IDX_W-1:0]] <= byte_in;
        end
    end

    assign bus.sda_oe       = drive_low;
    assign bus.busy         = active;
    assign bus.reg_wr_pulse = wr_pulse;
    assign bus.reg_addr     = ptr;
    assign bus.reg_wdata    = wdata;
endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_i2c_slave_responder                                |
// | Brief    : Bench driving I2C master transactions at the target   |
// |            and checking ACKs, read data and write strobes.       |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_i2c_slave_responder;
    logic pclk = 1'b0;
    logic areset = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic sda_line;
    int   errors = 0;
    int   checks = 0;
    int   oe_hits = 0;
    int   busy_hits = 0;
    string       tag_q[$];
    logic [15:0] val_q[$];
    logic [15:0] wr_q[$];

    i2c_slave_responder_if ifc();

    assign sda_line  = m_sda & ~ifc.sda_oe;
    assign ifc.scl_i = m_scl;
    assign ifc.sda_i = sda_line;

    i2c_slave_responder #(
        .SLAVE_ADDRESS (7'h68),
        .NO_OF_REG     (4),
        .DATA_WIDTH    (8)
    ) dut (
        .pclk   (pclk),
        .areset (areset),
        .bus    (ifc.slave)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic sb_check(input logic [15:0] obs);
        string       t;
        logic [15:0] v;
        check("scoreboard_nonempty", 32'(val_q.size() != 0), 32'd1);
        if (val_q.size() != 0) begin
            t = tag_q.pop_front();
            v = val_q.pop_front();
            check(t, {16'h0, obs}, {16'h0, v});
        end
    endtask

    // Each write strobe must match the oldest expected {addr, data}.
    always @(negedge pclk) begin
        logic [15:0] e;
        if (ifc.sda_oe) oe_hits++;
        if (ifc.busy)   busy_hits++;
        if (ifc.reg_wr_pulse) begin
            check("wr_pulse_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                check("wr_addr", {24'h0, ifc.reg_addr}, {24'h0, e[15:8]});
                check("wr_data", {24'h0, ifc.reg_wdata}, {24'h0, e[7:0]});
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clks(4);
        m_scl = 1'b1; wait_clks(4);
        m_sda = 1'b0; wait_clks(4);
        m_scl = 1'b0; wait_clks(4);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clks(4);
        m_scl = 1'b1; wait_clks(4);
        m_sda = 1'b1; wait_clks(4);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_clks(4);
        m_scl = 1'b1; wait_clks(8);
        m_scl = 1'b0; wait_clks(4);
    endtask

    task automatic recv_bit(output logic v);
        m_sda = 1'b1; wait_clks(4);
        m_scl = 1'b1; wait_clks(4);
        v = sda_line; wait_clks(4);
        m_scl = 1'b0; wait_clks(4);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack);
        logic v;
        sb_push($sformatf("ack_of_%02h", b), {15'h0, exp_ack});
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(v);
        sb_check({15'h0, ~v});
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic nack);
        logic [7:0] b;
        logic       v;
        sb_push("rd_byte", {8'h0, exp});
        for (int i = 7; i >= 0; i--) begin
            recv_bit(v);
            b[i] = v;
        end
        send_bit(nack);
        sb_check({8'h0, b});
    endtask

    initial begin
        int base_oe;
        int base_busy;
        int waited;

        // Reset state
        wait_clks(5);
        check("rst_sda_oe", 32'(ifc.sda_oe), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_wr_pulse", 32'(ifc.reg_wr_pulse), 32'd0);
        check("rst_reg_addr", 32'(ifc.reg_addr), 32'd0);
        check("rst_reg_wdata", 32'(ifc.reg_wdata), 32'd0);
        areset = 1'b1;
        wait_clks(5);

        // Write 0xA5 to register 2
        i2c_start();
        write_byte(8'hD0, 1'b1);
        check("busy_after_addr", 32'(ifc.busy), 32'd1);
        write_byte(8'h02, 1'b1);
        wr_q.push_back({8'h02, 8'hA5});
        write_byte(8'hA5, 1'b1);
        i2c_stop();
        wait_clks(4);
        check("busy_after_stop", 32'(ifc.busy), 32'd0);

        // Register-addressed read with master NACK
        i2c_start();
        write_byte(8'hD0, 1'b1);
        write_byte(8'h02, 1'b1);
        i2c_start();
        write_byte(8'hD1, 1'b1);
        read_byte(8'hA5, 1'b1);
        check("oe_after_nack", 32'(ifc.sda_oe), 32'd0);
        i2c_stop();
        wait_clks(4);
        check("busy_after_read", 32'(ifc.busy), 32'd0);

        // Address mismatch
        base_oe   = oe_hits;
        base_busy = busy_hits;
        i2c_start();
        write_byte(8'hD8, 1'b0);
        write_byte(8'h01, 1'b0);
        i2c_stop();
        check("mismatch_oe_cycles", 32'(oe_hits), 32'(base_oe));
        check("mismatch_busy_cycles", 32'(busy_hits), 32'(base_busy));

        // Bad register address, trailing data ignored
        i2c_start();
        write_byte(8'hD0, 1'b1);
        write_byte(8'h07, 1'b0);
        write_byte(8'h55, 1'b0);
        i2c_stop();
        i2c_start();
        write_byte(8'hD0, 1'b1);
        write_byte(8'h02, 1'b1);
        i2c_start();
        write_byte(8'hD1, 1'b1);
        read_byte(8'hA5, 1'b1);
        i2c_stop();

        // Burst write wrapping 3 -> 0, read back across the wrap
        i2c_start();
        write_byte(8'hD0, 1'b1);
        write_byte(8'h03, 1'b1);
        wr_q.push_back({8'h03, 8'h11});
        write_byte(8'h11, 1'b1);
        wr_q.push_back({8'h00, 8'h22});
        write_byte(8'h22, 1'b1);
        i2c_stop();
        i2c_start();
        write_byte(8'hD0, 1'b1);
        write_byte(8'h03, 1'b1);
        i2c_start();
        write_byte(8'hD1, 1'b1);
        read_byte(8'h11, 1'b0);
        read_byte(8'h22, 1'b1);
        i2c_stop();

        // Reset while the target drives the leading 0 bit of 0x22
        i2c_start();
        write_byte(8'hD0, 1'b1);
        write_byte(8'h00, 1'b1);
        i2c_start();
        write_byte(8'hD1, 1'b1);
        waited = 0;
        while (!ifc.sda_oe && waited < 40) begin
            wait_clks(1);
            waited++;
        end
        check("read_bit_driven", 32'(ifc.sda_oe), 32'd1);
        areset = 1'b0;
        #1;
        check("oe_async_reset", 32'(ifc.sda_oe), 32'd0);
        check("busy_async_reset", 32'(ifc.busy), 32'd0);
        wait_clks(5);
        areset = 1'b1;
        wait_clks(5);

        // Fresh write after reset, then read every register
        i2c_start();
        write_byte(8'hD0, 1'b1);
        write_byte(8'h01, 1'b1);
        wr_q.push_back({8'h01, 8'h3C});
        write_byte(8'h3C, 1'b1);
        i2c_stop();
        i2c_start();
        write_byte(8'hD0, 1'b1);
        write_byte(8'h00, 1'b1);
        i2c_start();
        write_byte(8'hD1, 1'b1);
        read_byte(8'h00, 1'b0);
        read_byte(8'h3C, 1'b0);
        read_byte(8'h00, 1'b0);
        read_byte(8'h00, 1'b1);
        i2c_stop();
        wait_clks(8);

        check("wr_pulses_outstanding", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- RTL I2C target (responder) for the I2C AVIP DUT side. It is the counterpart of the master-side transfer FSM: START, 7-bit slave address, RD_WR, SLAVE_ACK, register address, data, ACK, STOP.
- It decodes bus traffic addressed to it, holds a small byte register file, and acknowledges or returns data via open-drain SDA control.
- Bits are MSB first, as in all global-package transfers.

Parameters:
- SLAVE_ADDRESS, 7'h68, this target's 7-bit address (SLAVE0_ADDRESS).
- NO_OF_REG, 4, number of 8-bit registers; legal register addresses are 0..NO_OF_REG-1.
- DATA_WIDTH, 8, byte width; fixed at 8.

Ports:
- pclk  input  1  system clock; must be at least 8x SCL frequency.
- areset  input  1  asynchronous, active-low reset.
- scl_i  input  1  raw SCL pin level (asynchronous).
- sda_i  input  1  raw SDA pin level (asynchronous).
- sda_oe  output  1  1 = pull SDA low; 0 = release (pulled high externally).
- busy  output  1  high from an address-matched START until STOP or mismatch.
- reg_wr_pulse  output  1  one-pclk strobe when a data byte is written.
- reg_addr  output  8  current register pointer.
- reg_wdata  output  8  byte written; valid with reg_wr_pulse.

Behaviour:
- Reset: all outputs 0. Registers clear to 8'h00. FSM goes to IDLE. Pointer is 0. Reset is asserted asynchronously, released synchronously.
- Input path: scl_i and sda_i each pass through a 2-flop synchronizer plus one history flop. Edges and conditions are detected 3 pclk after a pin change.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are honoured in any state.
  - START (including repeated START) goes to ADDR, clears the bit counter and releases sda_oe.
  - STOP goes to IDLE, releases sda_oe and drops busy.
- Timing rules:
  - Receive bits are sampled on the detected SCL rising edge.
  - sda_oe changes only on the detected SCL falling edge, within 1 pclk of detection.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
    - Match goes to ADDR_ACK and sets busy.
    - Mismatch goes to IGNORE, with sda_oe 0 until START/STOP.
  - ADDR_ACK: drive sda_oe=1 for one SCL cycle.
    - R/W=0 goes to REG_ADDR.
    - R/W=1 goes to RD_DATA; the pointer byte is loaded into the shift register on the ACK SCL falling edge.
  - REG_ADDR: shift 8 bits.
    - Value < NO_OF_REG: load pointer and ACK, then go to WR_DATA.
    - Otherwise: NACK (sda_oe stays 0) and go to IGNORE.
  - WR_DATA: shift 8 bits, then WR_ACK. In WR_ACK:
    - Store the byte at the pointer.
    - Pulse reg_wr_pulse on the cycle of the 8th sampled bit.
    - ACK.
    - Increment the pointer modulo NO_OF_REG (wraps from NO_OF_REG-1 to 0).
  - RD_DATA: on each SCL falling edge, drive the current bit (sda_oe = ~bit). After 8 bits, release and go to RD_ACK.
  - RD_ACK: sample the master bit on SCL rise.
    - ACK (0): increment pointer (wrap) and load the next byte into RD_DATA.
    - NACK (1): go to IGNORE (released) until STOP or repeated START.
- Register-addressed read (write pointer, repeated START, read): the pointer persists across repeated START. It is cleared only by reset.
- Bit counter is 3 bits and wraps at 8. Shift register is 8 bits, MSB first.
- Simultaneous events: a START/STOP detected in the same cycle as an SCL edge wins; the bit sample is discarded.
- Reset mid-transfer: sda_oe drops to 0 asynchronously. A bus still mid-byte is ignored until the next START.

Test Plan:
- Write: START, 0xD0, 0x02, 0xA5, STOP.
  - Target ACKs all 3 bytes.
  - reg_wr_pulse once, with reg_wdata=0xA5 and reg_addr=2.
  - Register 2 = 0xA5.
  - busy is 0 after STOP.
- Read: after the write above, START, 0xD0, 0x02, repeated START, 0xD1, master NACK, STOP.
  - Target drives 0xA5 MSB first.
  - sda_oe is 0 after the NACK bit.
- Address mismatch: START, 0xD8, 0x01, STOP.
  - sda_oe stays 0 throughout.
  - busy stays 0.
  - No reg_wr_pulse.
- Bad register: START, 0xD0, 0x07.
  - Address is ACKed; register byte is NACKed.
  - A following data byte 0x55 is ignored; registers are unchanged.
- Burst wrap: START, 0xD0, 0x03, 0x11, 0x22, STOP.
  - Register 3 = 0x11, register 0 = 0x22.
  - reg_addr=0 at the second pulse.
- Reset mid-read: assert areset while the target drives a 0 data bit.
  - sda_oe=0 within the same cycle.
  - All registers = 0x00.
  - After release, a fresh write transaction succeeds.
